mini_alu_gen2: RTL

MINI_ALU_GEN2 -- requirements
Module: mini_alu_gen2

---
 rtl/mini_alu_gen2_pkg.sv | 48 ++++
 rtl/mini_alu_gen2_if.sv | 13 +
 rtl/mini_alu_gen2_dp_ram.sv | 24 ++
 rtl/mini_alu_gen2_return_stack.sv | 39 +++
 rtl/mini_alu_gen2.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/mini_alu_gen2_pkg.sv
// mini_alu_gen2 shared definitions: opcodes, instruction
// layout (op[27:24] dst[23:16] src1[15:8] src0[7:0]), defaults.
package mini_alu_gen2_pkg;

   localparam int DATA_WIDTH_DEF     = 16;
   localparam int REG_ADDR_WIDTH_DEF = 4;
   localparam int IP_WIDTH_DEF       = 16;
   localparam int LED_WIDTH_DEF      = 8;
   localparam int STACK_DEPTH_DEF    = 4;

   localparam int INSTR_WIDTH = 28;
   localparam int OPC_LSB     = 24;
   localparam int DST_LSB     = 16;
   localparam int SRC1_LSB    = 8;
   localparam int SRC0_LSB    = 0;

   typedef enum logic [3:0] {
      OP_NOP   = 4'd0,
      OP_ADD   = 4'd1,
      OP_SUB   = 4'd2,
      OP_STO   = 4'd3,
      OP_BLE   = 4'd4,
      OP_JMP   = 4'd5,
      OP_LED   = 4'd6,
      OP_AND   = 4'd7,
      OP_OR    = 4'd8,
      OP_SHL   = 4'd9,
      OP_SHR   = 4'd10,
      OP_CALL  = 4'd11,
      OP_RET   = 4'd12,
      OP_HALT  = 4'd13,
      OP_ILL14 = 4'd14,
      OP_ILL15 = 4'd15
   } opcode_e;

   // Packed so that field order matches the ROM word bit positions.
   typedef struct packed {
      opcode_e    op;
      logic [7:0] dst;
      logic [7:0] src1;
      logic [7:0] src0;
   } instr_t;

   localparam instr_t INSTR_NOP = '{
      op: OP_NOP, dst: 8'h00, src1: 8'h00, src0: 8'h00
   };

endpackage

// File: rtl/mini_alu_gen2_if.sv
// Instruction ROM bus: core drives oIP, ROM returns
// iInstruction combinationally (master = core, slave = ROM).
interface mini_alu_gen2_if
   import mini_alu_gen2_pkg::*;
#(
   parameter int IP_WIDTH = IP_WIDTH_DEF
);
   logic [IP_WIDTH-1:0]    oIP;
   logic [INSTR_WIDTH-1:0] iInstruction;

   modport master (output oIP, input iInstruction);
   modport slave  (input oIP, output iInstruction);
endinterface

// File: rtl/mini_alu_gen2_dp_ram.sv
// Dual-read-port register RAM: one sync write port,
// two async read ports (raddr0_i/raddr1_i -> rdata0_o/rdata1_o).
module mini_alu_dp_ram #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 4
)(
   input  logic                  Clock,
   input  logic                  we_i,
   input  logic [ADDR_WIDTH-1:0] waddr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic [ADDR_WIDTH-1:0] raddr0_i,
   input  logic [ADDR_WIDTH-1:0] raddr1_i,
   output logic [DATA_WIDTH-1:0] rdata0_o,
   output logic [DATA_WIDTH-1:0] rdata1_o
);
   logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

   always_ff @(posedge Clock) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata0_o = mem_q[raddr0_i];
   assign rdata1_o = mem_q[raddr1_i];
endmodule

// File: rtl/mini_alu_gen2_return_stack.sv
// Return-address stack: push_i/pop_i, top_o is the top entry,
// full_o/empty_o status. Only the pointer is reset.
module mini_alu_return_stack #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 16
)(
   input  logic             Clock,
   input  logic             Reset,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] top_o,
   output logic             full_o,
   output logic             empty_o
);
   localparam int PW = $clog2(DEPTH + 1);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    sp_q;

   assign full_o  = (sp_q == PW'(DEPTH));
   assign empty_o = (sp_q == '0);
   assign top_o   = mem_q[AW'(sp_q - PW'(1))];

   always_ff @(posedge Clock) begin
      if (Reset) begin
         sp_q <= '0;
      end else if (push_i && !full_o) begin
         sp_q <= sp_q + PW'(1);
      end else if (pop_i && !empty_o) begin
         sp_q <= sp_q - PW'(1);
      end
   end

   always_ff @(posedge Clock) begin
      if (!Reset && push_i && !full_o) mem_q[AW'(sp_q)] <= data_i;
   end
endmodule

// File: rtl/mini_alu_gen2.sv
// Two-stage mini ALU core. Ports: Clock, Reset (sync, high),
// rom (oIP/iInstruction ROM bus), oLed, oHalted, oError.
module mini_alu_gen2
   import mini_alu_gen2_pkg::*;
#(
   parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
   parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF,
   parameter int IP_WIDTH       = IP_WIDTH_DEF,
   parameter int LED_WIDTH      = LED_WIDTH_DEF,
   parameter int STACK_DEPTH    = STACK_DEPTH_DEF
)(
   input  logic                 Clock,
   input  logic                 Reset,
   mini_alu_gen2_if.master      rom,
   output logic [LED_WIDTH-1:0] oLed,
   output logic                 oHalted,
   output logic                 oError
);
   localparam int SHW = $clog2(DATA_WIDTH);
   localparam int AW  = REG_ADDR_WIDTH;

   instr_t                ex_q, ex_d;
   logic [IP_WIDTH-1:0]   ip_q, ip_d;
   logic [LED_WIDTH-1:0]  led_q, led_d;
   logic                  halted_q, halted_d;
   logic                  err_q, err_d;

   logic [DATA_WIDTH-1:0] rd0, rd1, wdata;
   logic [IP_WIDTH-1:0]   br_tgt, stk_top;
   logic                  we, taken, push, pop;
   logic                  full, empty;

   mini_alu_dp_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (AW)
   ) u_rf (
      .Clock    (Clock),
      .we_i     (we && !Reset),
      .waddr_i  (ex_q.dst[AW-1:0]),
      .wdata_i  (wdata),
      .raddr0_i (ex_q.src0[AW-1:0]),
      .raddr1_i (ex_q.src1[AW-1:0]),
      .rdata0_o (rd0),
      .rdata1_o (rd1)
   );

   mini_alu_return_stack #(
      .DEPTH (STACK_DEPTH),
      .WIDTH (IP_WIDTH)
   ) u_stk (
      .Clock   (Clock),
      .Reset   (Reset),
      .push_i  (push),
      .pop_i   (pop),
      .data_i  (ip_q),
      .top_o   (stk_top),
      .full_o  (full),
      .empty_o (empty)
   );

   // Execute stage. While halted ex_q holds NOP, so nothing
   // below can write state.
   always_comb begin
      we       = 1'b0;
      wdata    = '0;
      taken    = 1'b0;
      br_tgt   = IP_WIDTH'(ex_q.dst);
      push     = 1'b0;
      pop      = 1'b0;
      led_d    = led_q;
      halted_d = halted_q;
      err_d    = err_q;
      unique case (ex_q.op)
         OP_NOP: begin
         end
         OP_ADD: begin
            we    = 1'b1;
            wdata = rd1 + rd0;
         end
         OP_SUB: begin
            we    = 1'b1;
            wdata = rd1 - rd0;
         end
         OP_STO: begin
            we    = 1'b1;
            wdata = DATA_WIDTH'({ex_q.src1, ex_q.src0});
         end
         OP_BLE: taken = (rd1 <= rd0);
         OP_JMP: taken = 1'b1;
         OP_LED: led_d = rd1[LED_WIDTH-1:0];
         OP_AND: begin
            we    = 1'b1;
            wdata = rd1 & rd0;
         end
         OP_OR: begin
            we    = 1'b1;
            wdata = rd1 | rd0;
         end
         OP_SHL: begin
            we    = 1'b1;
            wdata = rd1 << rd0[SHW-1:0];
         end
         OP_SHR: begin
            we    = 1'b1;
            wdata = rd1 >> rd0[SHW-1:0];
         end
         OP_CALL: begin
            if (full) begin
               err_d = 1'b1;
            end else begin
               push  = 1'b1;
               taken = 1'b1;
            end
         end
         OP_RET: begin
            if (empty) begin
               err_d = 1'b1;
            end else begin
               pop    = 1'b1;
               taken  = 1'b1;
               br_tgt = stk_top;
            end
         end
         OP_HALT: halted_d = 1'b1;
         default: err_d = 1'b1;
      endcase
   end

   // Taken branches redirect the fetch in the same cycle,
   // so the fall-through word is never loaded.
   assign rom.oIP = taken ? br_tgt : ip_q;

   always_comb begin
      if (halted_d) begin
         ip_d = ip_q;
         ex_d = INSTR_NOP;
      end else begin
         ip_d = rom.oIP + IP_WIDTH'(1);
         ex_d = instr_t'(rom.iInstruction);
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         ip_q     <= '0;
         ex_q     <= INSTR_NOP;
         led_q    <= '0;
         halted_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         ip_q     <= ip_d;
         ex_q     <= ex_d;
         led_q    <= led_d;
         halted_q <= halted_d;
         err_q    <= err_d;
      end
   end

   assign oLed    = led_q;
   assign oHalted = halted_q;
   assign oError  = err_q;
endmodule
